phase_slot_sequencer: RTL and testbench

//  Time-division controller for the 18-slot phase RAM of the FM operator pipeline.

---
 rtl/phase_slot_sequencer_pkg.sv | 22 ++
 rtl/phase_slot_sequencer.sv | 86 ++++++++
 tb/tb_phase_slot_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_slot_sequencer_pkg.sv
// Shared types and defaults for the phase RAM slot sequencer.
// Phase width matches the vm2413 operator pipeline.
package phase_slot_sequencer_pkg;

   localparam int PHASE_BITS  = 18;
   localparam int SLOT_COUNT  = 18;
   localparam int INIT_SWEEP  = 18;

   typedef logic [PHASE_BITS-1:0] PHASE_TYPE;
   typedef logic [4:0]            SLOT_TYPE;
   typedef logic [1:0]            stage_t;

   typedef enum logic {
      SEQ_INIT,
      SEQ_RUN
   } seq_state_t;

   function automatic SLOT_TYPE slot_next(input SLOT_TYPE cur, input SLOT_TYPE last);
      return (cur == last) ? SLOT_TYPE'(0) : SLOT_TYPE'(cur + 5'd1);
   endfunction

endpackage

// File: rtl/phase_slot_sequencer.sv
// Walks the phase RAM slots in a 4-stage frame and performs phase read-modify-write.
// Writes are held off while the RAM clears itself after reset.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  SEQ_INIT | RAM clear sweep running; slot/stage parked at 0, no writes
//  SEQ_RUN  | stage 0..3 per slot on clkena: address, read, add, write-back
module phase_slot_sequencer
   import phase_slot_sequencer_pkg::*;
#(
   parameter int PHASE_W     = PHASE_BITS,
   parameter int SLOTS       = SLOT_COUNT,
   parameter int INIT_CYCLES = INIT_SWEEP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clkena,
   input  logic [PHASE_W-1:0] memout,
   input  logic [PHASE_W-1:0] inc,
   input  logic               kon_restart,
   output SLOT_TYPE           slot,
   output stage_t             stage,
   output logic               memwr,
   output logic [PHASE_W-1:0] memin,
   output logic [PHASE_W-1:0] phase_out,
   output logic               phase_valid,
   output logic               init_busy
);

   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
   localparam SLOT_TYPE LAST_SLOT = SLOT_TYPE'(SLOTS - 1);

   seq_state_t         state;
   logic [CNT_W-1:0]   init_cnt;
   logic [PHASE_W-1:0] sum_q;

   // Write strobe is gated combinationally so it can never outlive clkena or reset.
   assign memwr = (state == SEQ_RUN) && (stage == 2'd3) && clkena && !reset;
   assign memin = sum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SEQ_INIT;
         init_cnt    <= CNT_LOAD;
         init_busy   <= 1'b1;
         slot        <= '0;
         stage       <= '0;
         sum_q       <= '0;
         phase_out   <= '0;
         phase_valid <= 1'b0;
      end else begin
         // phase_valid is a strobe, so it falls even on stalled cycles.
         phase_valid <= 1'b0;
         case (state)
            SEQ_INIT: begin
               if (init_cnt == '0) begin
                  state     <= SEQ_RUN;
                  init_busy <= 1'b0;
                  slot      <= '0;
                  stage     <= '0;
               end else begin
                  init_cnt <= init_cnt - 1'b1;
               end
            end
            SEQ_RUN: begin
               if (clkena) begin
                  stage <= stage + 2'd1;
                  if (stage == 2'd2) begin
                     sum_q <= kon_restart ? '0 : memout + inc;
                  end
                  if (stage == 2'd3) begin
                     slot        <= slot_next(slot, LAST_SLOT);
                     phase_out   <= sum_q;
                     phase_valid <= 1'b1;
                  end
               end
            end
            default: begin
               state <= SEQ_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_slot_sequencer.sv
// Directed bench for phase_slot_sequencer with a behavioural phase RAM.
// Expected phases are hand-derived from the per-slot increments.
module tb_phase_slot_sequencer;

   logic        clk;
   logic        reset;
   logic        clkena;
   logic [17:0] memout;
   logic [17:0] inc;
   logic        kon_restart;
   logic [4:0]  slot;
   logic [1:0]  stage;
   logic        memwr;
   logic [17:0] memin;
   logic [17:0] phase_out;
   logic        phase_valid;
   logic        init_busy;

   int vectors;
   int miscompares;
   int cyc;

   logic [17:0] ram     [0:31];
   logic [17:0] inc_tbl [0:31];
   logic        kon_en;
   logic [4:0]  kon_slot;
   logic        pre_en;
   logic [4:0]  pre_addr;
   logic [17:0] pre_val;

   phase_slot_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .clkena      (clkena),
      .memout      (memout),
      .inc         (inc),
      .kon_restart (kon_restart),
      .slot        (slot),
      .stage       (stage),
      .memwr       (memwr),
      .memin       (memin),
      .phase_out   (phase_out),
      .phase_valid (phase_valid),
      .init_busy   (init_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign inc         = inc_tbl[slot];
   assign kon_restart = kon_en && (slot == kon_slot) && (stage == 2'd2);

   // Phase RAM: registered read, write on memwr, cleared by reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) ram[i] <= '0;
         memout <= '0;
      end else begin
         if (pre_en) ram[pre_addr] <= pre_val;
         if (memwr) ram[slot] <= memin;
         memout <= ram[slot];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_inc_all(input logic [17:0] v);
      for (int i = 0; i < 32; i++) inc_tbl[i] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_init(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!init_busy) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Waits for the write of slot s; returns at the negedge after the write edge.
   task automatic wait_wr(input logic [4:0] s, output logic [17:0] val, output bit ok);
      ok  = 1'b0;
      val = '0;
      for (int i = 0; i < 400; i++) begin
         if (memwr && slot == s) begin
            val = memin;
            ok  = 1'b1;
            step();
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      @(negedge clk);
      vectors++;
      if (slot !== 5'd0 || stage !== 2'd0 || memwr !== 1'b0 || memin !== 18'd0 ||
          phase_out !== 18'd0 || phase_valid !== 1'b0 || init_busy !== 1'b1) begin
         $display("FAIL reset_values: slot=%0d stage=%0d memwr=%b memin=%h phase_out=%h pv=%b busy=%b, need 0/0/0/0/0/0/1",
                  slot, stage, memwr, memin, phase_out, phase_valid, init_busy);
         miscompares++;
      end
   endtask

   task automatic test_init_first_write();
      set_inc_all(18'd1);
      step();
      reset = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         step();
         vectors++;
         if (init_busy !== (i < 18) || memwr !== 1'b0 || stage !== 2'd0 || slot !== 5'd0) begin
            $display("FAIL init_sweep clk %0d: busy=%b memwr=%b stage=%0d slot=%0d, need busy=%b 0 0 0",
                     i, init_busy, memwr, stage, slot, (i < 18));
            miscompares++;
         end
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         vectors++;
         if (memwr !== (i == 3) || stage !== 2'(i) || slot !== 5'd0) begin
            $display("FAIL first_frame stage %0d: memwr=%b stage=%0d slot=%0d, need memwr=%b slot 0",
                     i, memwr, stage, slot, (i == 3));
            miscompares++;
         end
      end
      vectors++;
      if (memin !== 18'd1) begin
         $display("FAIL first_write_data: memin=%h need 00001", memin);
         miscompares++;
      end
      step();
      vectors++;
      if (phase_valid !== 1'b1 || phase_out !== 18'd1 || slot !== 5'd1 || stage !== 2'd0 || memwr !== 1'b0) begin
         $display("FAIL first_phase_out: pv=%b phase_out=%h slot=%0d stage=%0d memwr=%b, need 1 00001 1 0 0",
                  phase_valid, phase_out, slot, stage, memwr);
         miscompares++;
      end
      step();
      vectors++;
      if (phase_valid !== 1'b0) begin
         $display("FAIL phase_valid_strobe: pv=%b need 0", phase_valid);
         miscompares++;
      end
   endtask

   task automatic test_accumulate();
      logic [17:0] v;
      bit ok;
      int t0;
      set_inc_all(18'h00100);
      do_reset();
      wait_init(ok);
      wait_wr(5'd5, v, ok);
      wait_wr(5'd5, v, ok);
      vectors++;
      if (!ok || v !== 18'h00200) begin
         $display("FAIL accum_frame2: ok=%b memin=%h need 00200", ok, v);
         miscompares++;
      end
      wait_wr(5'd5, v, ok);
      vectors++;
      if (!ok || v !== 18'h00300) begin
         $display("FAIL accum_frame3: ok=%b memin=%h need 00300", ok, v);
         miscompares++;
      end
      vectors++;
      if (phase_valid !== 1'b1 || phase_out !== 18'h00300) begin
         $display("FAIL accum_phase_out: pv=%b phase_out=%h need 1 00300", phase_valid, phase_out);
         miscompares++;
      end
      t0 = cyc;
      wait_wr(5'd5, v, ok);
      vectors++;
      if (!ok || (cyc - t0) != 72 || v !== 18'h00400) begin
         $display("FAIL frame_period: ok=%b period=%0d memin=%h need 72 00400", ok, cyc - t0, v);
         miscompares++;
      end
      wait_wr(5'd17, v, ok);
      vectors++;
      if (!ok || slot !== 5'd0 || v !== 18'h00400) begin
         $display("FAIL slot_wrap: ok=%b next slot=%0d memin=%h need 0 00400", ok, slot, v);
         miscompares++;
      end
   endtask

   task automatic test_wrap();
      logic [17:0] v;
      bit ok;
      set_inc_all(18'h00020);
      do_reset();
      wait_init(ok);
      pre_en   = 1'b1;
      pre_addr = 5'd7;
      pre_val  = 18'h3FFF0;
      step();
      pre_en = 1'b0;
      wait_wr(5'd7, v, ok);
      vectors++;
      if (!ok || v !== 18'h00010) begin
         $display("FAIL phase_wrap: ok=%b memin=%h need 00010", ok, v);
         miscompares++;
      end
   endtask

   task automatic test_restart();
      logic [17:0] v;
      bit ok;
      set_inc_all(18'h00055);
      kon_slot = 5'd3;
      kon_en   = 1'b0;
      do_reset();
      wait_init(ok);
      wait_wr(5'd3, v, ok);
      vectors++;
      if (!ok || v !== 18'h00055) begin
         $display("FAIL restart_pre: ok=%b memin=%h need 00055", ok, v);
         miscompares++;
      end
      kon_en = 1'b1;
      wait_wr(5'd3, v, ok);
      kon_en = 1'b0;
      vectors++;
      if (!ok || v !== 18'h00000) begin
         $display("FAIL restart_slot3: ok=%b memin=%h need 00000", ok, v);
         miscompares++;
      end
      wait_wr(5'd4, v, ok);
      vectors++;
      if (!ok || v !== 18'h000AA) begin
         $display("FAIL restart_other_slot: ok=%b memin=%h need 000AA", ok, v);
         miscompares++;
      end
      wait_wr(5'd2, v, ok);
      vectors++;
      if (!ok || v !== 18'h000FF) begin
         $display("FAIL restart_slot2_frame3: ok=%b memin=%h need 000FF", ok, v);
         miscompares++;
      end
      wait_wr(5'd3, v, ok);
      vectors++;
      if (!ok || v !== 18'h00055) begin
         $display("FAIL restart_resume: ok=%b memin=%h need 00055", ok, v);
         miscompares++;
      end
   endtask

   task automatic test_clkena();
      bit ok;
      int s17_writes;
      int bad;
      for (int i = 0; i < 32; i++) inc_tbl[i] = 18'(i * 16 + 1);
      do_reset();
      wait_init(ok);
      s17_writes = 0;
      bad = 0;
      for (int i = 0; i < 1000 && s17_writes < 2; i++) begin
         clkena = ($urandom_range(0, 2) != 0);
         #1;
         if (memwr !== (clkena && stage == 2'd3)) begin
            if (bad == 0)
               $display("FAIL clkena_gating: memwr=%b clkena=%b stage=%0d", memwr, clkena, stage);
            bad++;
         end
         if (memwr && slot == 5'd17) s17_writes++;
         step();
      end
      clkena = 1'b1;
      step();
      vectors++;
      if (bad != 0 || s17_writes != 2) begin
         $display("FAIL clkena_run: gating errors=%0d slot17 writes=%0d, need 0 and 2", bad, s17_writes);
         miscompares++;
      end
      for (int s = 0; s < 18; s++) begin
         vectors++;
         if (ram[s] !== 18'(2 * (s * 16 + 1))) begin
            $display("FAIL clkena_result slot %0d: phase=%h need %h", s, ram[s], 18'(2 * (s * 16 + 1)));
            miscompares++;
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [17:0] v;
      bit ok;
      set_inc_all(18'h00100);
      do_reset();
      wait_init(ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (memwr && slot == 5'd9) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (!ok || memwr !== 1'b0 || slot !== 5'd0 || init_busy !== 1'b1) begin
         $display("FAIL reset_in_st3: found=%b memwr=%b slot=%0d busy=%b, need 1 0 0 1", ok, memwr, slot, init_busy);
         miscompares++;
      end
      step();
      reset = 1'b0;
      wait_init(ok);
      wait_wr(5'd9, v, ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (slot == 5'd9 && stage == 2'd2) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (!ok || memwr !== 1'b0 || slot !== 5'd0 || stage !== 2'd0 || phase_valid !== 1'b0 || init_busy !== 1'b1) begin
         $display("FAIL reset_in_st2: found=%b memwr=%b slot=%0d stage=%0d pv=%b busy=%b, need 1 0 0 0 0 1",
                  ok, memwr, slot, stage, phase_valid, init_busy);
         miscompares++;
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         step();
         if (i == 17 || i == 18) begin
            vectors++;
            if (init_busy !== (i < 18)) begin
               $display("FAIL reinit_busy clk %0d: busy=%b need %b", i, init_busy, (i < 18));
               miscompares++;
            end
         end
      end
      wait_wr(5'd0, v, ok);
      vectors++;
      if (!ok || v !== 18'h00100) begin
         $display("FAIL reinit_slot0: ok=%b memin=%h need 00100", ok, v);
         miscompares++;
      end
      wait_wr(5'd9, v, ok);
      vectors++;
      if (!ok || v !== 18'h00100) begin
         $display("FAIL reinit_slot9: ok=%b memin=%h need 00100", ok, v);
         miscompares++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      reset       = 1'b1;
      clkena      = 1'b1;
      kon_en      = 1'b0;
      kon_slot    = 5'd0;
      pre_en      = 1'b0;
      pre_addr    = 5'd0;
      pre_val     = 18'd0;
      set_inc_all(18'd0);

      test_reset();
      test_init_first_write();
      test_accumulate();
      test_wrap();
      test_restart();
      test_clkena();
      test_reset_midframe();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
